// File: rtl/uc_multiciclo_if.sv
// Control bus between the multi-cycle sequencer and the datapath.
// master = controller side, slave = datapath side.
interface uc_multiciclo_if;
  logic [5:0] Opcode;
  logic       zero;
  logic       pc_en;
  logic       ir_en;
  logic       s_inc;
  logic       s_inm;
  logic       we;
  logic       wez;
  logic [2:0] ALUOp;
  logic       halted;
  logic       illegal;

  modport master (
    input  Opcode, zero,
    output pc_en, ir_en, s_inc, s_inm,
    output we, wez, ALUOp, halted, illegal
  );

  modport slave (
    output Opcode, zero,
    input  pc_en, ir_en, s_inc, s_inm,
    input  we, wez, ALUOp, halted, illegal
  );
endinterface

// File: rtl/uc_multiciclo.sv
// Multi-cycle FETCH/DECODE/EXECUTE control unit with run/halt and wait states.
// Optional single-step mode: define UC_SINGLE_STEP_EN.
module uc_multiciclo #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
`ifdef UC_SINGLE_STEP_EN
  input  logic step,
`endif
  uc_multiciclo_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
`ifdef UC_SINGLE_STEP_EN
    S_PAUSE,
`endif
    S_HALT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
`ifdef UC_SINGLE_STEP_EN
  logic       step_q, step_d;
`endif

  logic [5:0] op;
  logic       is_halt;
  logic       is_alu;
  logic       is_li;
  logic       is_j;
  logic       is_jz;
  logic       is_jnz;

  logic [2:0] dec_alu;
  logic       dec_s_inc;
  logic       dec_s_inm;
  logic       dec_we;
  logic       dec_wez;
  logic       dec_bad;

  assign op = bus.Opcode;

  // Decode terms are made disjoint so HALT_OPCODE may overlap any class.
  assign is_halt = (op == HALT_OPCODE);
  assign is_alu  = (op[5:3] == 3'b000) && !is_halt;
  assign is_li   = (op[5:3] == 3'b001) && !is_halt;
  assign is_j    = (op == 6'b010000) && !is_halt;
  assign is_jz   = (op == 6'b010001) && !is_halt;
  assign is_jnz  = (op == 6'b010010) && !is_halt;

  always_comb begin
    dec_alu   = 3'b000;
    dec_s_inc = 1'b1;
    dec_s_inm = 1'b0;
    dec_we    = 1'b0;
    dec_wez   = 1'b0;
    dec_bad   = 1'b0;
    unique case (1'b1)
      is_halt: begin
      end
      is_alu: begin
        dec_alu = op[2:0];
        dec_we  = 1'b1;
        dec_wez = 1'b1;
      end
      is_li: begin
        dec_s_inm = 1'b1;
        dec_we    = 1'b1;
      end
      is_j:   dec_s_inc = 1'b0;
      is_jz:  dec_s_inc = ~bus.zero;
      is_jnz: dec_s_inc = bus.zero;
      default: dec_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
`ifdef UC_SINGLE_STEP_EN
    step_d    = step;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (cnt_q == 4'(WAIT_STATES)) begin
          cnt_d   = 4'd0;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        illegal_d = illegal_q | dec_bad;
        state_d   = is_halt ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
`ifdef UC_SINGLE_STEP_EN
        state_d = S_PAUSE;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef UC_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step && !step_q) state_d = S_FETCH;
      end
`endif
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pc_en   = 1'b0;
    bus.ir_en   = 1'b0;
    bus.s_inc   = 1'b1;
    bus.s_inm   = 1'b0;
    bus.we      = 1'b0;
    bus.wez     = 1'b0;
    bus.ALUOp   = 3'b000;
    bus.halted  = 1'b0;
    bus.illegal = illegal_q;
    unique case (state_q)
      S_DECODE: bus.ir_en = 1'b1;
      S_EXECUTE: begin
        bus.pc_en = 1'b1;
        bus.s_inc = dec_s_inc;
        bus.s_inm = dec_s_inm;
        bus.we    = dec_we;
        bus.wez   = dec_wez;
        bus.ALUOp = dec_alu;
      end
      S_HALT: bus.halted = 1'b1;
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
`ifdef UC_SINGLE_STEP_EN
      step_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
`ifdef UC_SINGLE_STEP_EN
      step_q    <= step_d;
`endif
    end
  end

endmodule
